// File: rtl/count_display.sv
// count_display: converts an 8-bit event count to three BCD digits with a
// shift-and-add-3 FSM and drives a multiplexed 7-segment display.
//
// Parameters:
//   SCAN_DIV  clock cycles each digit stays enabled before the scan advances (2..65535)
// Ports:
//   clk    sole clock, rising edge
//   rst    asynchronous active-high reset
//   count  [7:0] binary event count, synchronous to clk
//   seg    [6:0] segment drive {g,f,e,d,c,b,a}, active-high
//   an     [2:0] one-hot digit enable: [0] units, [1] tens, [2] hundreds
//   busy   high while a binary-to-BCD conversion is in progress
//
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zeros on the
// hundreds and tens digits. The units digit is never blanked.
//
// Timing: a change on count is captured at edge k. The display registers are
// written at edge k+9, and the next change can be captured at edge k+10.
// Changes that arrive while busy are not queued. The FSM re-compares in IDLE
// and converts only the latest value.

module count_display #(
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] count,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [15:0] LP_SCAN_TERM = 16'(SCAN_DIV - 1);

  state_t      r_state;
  logic        r_busy;
  logic [7:0]  r_last;
  logic [7:0]  r_bin;
  logic [11:0] r_bcd;
  logic [2:0]  r_bit_cnt;
  logic [3:0]  r_hund;
  logic [3:0]  r_tens;
  logic [3:0]  r_units;
  logic [15:0] r_presc;
  logic [1:0]  r_ptr;

  logic [11:0] w_adj;
  logic [3:0]  w_digit;
  logic        w_blank;

  // Add-3 correction. It is applied before each shift so that no BCD nibble
  // can exceed 9 after the shift.
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < 3; i++) begin
      if (r_bcd[i*4 +: 4] >= 4'd5) begin
        w_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
      end
    end
  end

  // Conversion FSM: IDLE (compare) -> SHIFT (8 cycles) -> DONE (commit).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_busy    <= 1'b0;
      r_last    <= 8'd0;
      r_bin     <= 8'd0;
      r_bcd     <= 12'd0;
      r_bit_cnt <= 3'd0;
      r_hund    <= 4'd0;
      r_tens    <= 4'd0;
      r_units   <= 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (count != r_last) begin
            r_bin     <= count;
            r_last    <= count;
            r_bcd     <= 12'd0;
            r_bit_cnt <= 3'd0;
            r_busy    <= 1'b1;
            r_state   <= SHIFT;
          end
        end
        SHIFT: begin
          r_bcd     <= {w_adj[10:0], r_bin[7]};
          r_bin     <= {r_bin[6:0], 1'b0};
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          r_hund  <= r_bcd[11:8];
          r_tens  <= r_bcd[7:4];
          r_units <= r_bcd[3:0];
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;

  // Scan prescaler and digit pointer. These run independently of the conversion FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= 16'd0;
      r_ptr   <= 2'd0;
    end else if (r_presc == LP_SCAN_TERM) begin
      r_presc <= 16'd0;
      r_ptr   <= (r_ptr == 2'd2) ? 2'd0 : r_ptr + 2'd1;
    end else begin
      r_presc <= r_presc + 16'd1;
    end
  end

  // Digit select and enable are combinational from registers. A display
  // register update shows on the current digit in the next cycle.
  always_comb begin
    case (r_ptr)
      2'd0:    begin an = 3'b001; w_digit = r_units; end
      2'd1:    begin an = 3'b010; w_digit = r_tens;  end
      default: begin an = 3'b100; w_digit = r_hund;  end
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  assign w_blank = ((r_ptr == 2'd2) && (r_hund == 4'd0)) ||
                   ((r_ptr == 2'd1) && (r_hund == 4'd0) && (r_tens == 4'd0));
`else
  assign w_blank = 1'b0;
`endif

  always_comb begin
    case (w_digit)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = 7'h00;
    endcase
    if (w_blank) begin
      seg = 7'h00;
    end
  end

endmodule
